sha256_core_dispatch: RTL and testbench

//  Job scheduler between the unit input path and N_CORES sha256 cores sharing one write bus.

---
 rtl/sha256_core_dispatch_pkg.sv | 24 ++
 rtl/sha256_core_dispatch_rr_arbiter.sv | 31 +++
 rtl/sha256_core_dispatch.sv | 162 ++++++++++++++++
 tb/tb_sha256_core_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_core_dispatch_pkg.sv
// rtl/sha256_core_dispatch_pkg.sv - shared constants, FSM encoding and width helper for the sha256 job dispatcher
package sha256_core_dispatch_pkg;

  localparam int         BLK_OP_MSB      = 1;
  localparam int         WORDS_PER_BLOCK = 16;
  localparam logic [3:0] LAST_WORD       = 4'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2
  } state_e;

  // Index of the highest set bit; 0 for 0 so a single core still gets a 1-bit index.
  function automatic int msb(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (value[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_core_dispatch_rr_arbiter.sv
// rtl/sha256_core_dispatch_rr_arbiter.sv - combinational round-robin pick: first requester after ptr, wrapping
module sha256_core_dispatch_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    // ptr itself is searched last, so the previous winner has lowest priority.
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_core_dispatch.sv
// rtl/sha256_core_dispatch.sv - streams 16-word block jobs into a round-robin selected sha256 core, then starts it
module sha256_core_dispatch
  import sha256_core_dispatch_pkg::*;
#(
  parameter int N_CORES     = 3,
  parameter int N_CORES_MSB = msb(N_CORES - 1)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [31:0]         job_data,
  input  logic [BLK_OP_MSB:0] job_blk_op,
  input  logic [N_CORES-1:0]  core_ready,
  output logic [N_CORES-1:0]  core_wr_en,
  output logic [31:0]         core_din,
  output logic [3:0]          core_wr_addr,
  output logic [BLK_OP_MSB:0] core_blk_op,
  output logic                core_seq,
  output logic                core_set_input_ready,
  output logic [N_CORES-1:0]  core_start,
  output logic                busy
);

  localparam int IDX_W = N_CORES_MSB + 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sel_q, sel_d;
  logic [N_CORES-1:0]  sel_oh_q, sel_oh_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]          word_cnt_q, word_cnt_d;
  logic [BLK_OP_MSB:0] blk_op_lat_q, blk_op_lat_d;
  logic [N_CORES-1:0]  seq_bit_q, seq_bit_d;
  logic                job_ready_q, job_ready_d;
  logic                busy_q, busy_d;
  logic [N_CORES-1:0]  core_wr_en_q, core_wr_en_d;
  logic [31:0]         core_din_q, core_din_d;
  logic [3:0]          core_wr_addr_q, core_wr_addr_d;
  logic [BLK_OP_MSB:0] core_blk_op_q, core_blk_op_d;
  logic                core_seq_q, core_seq_d;
  logic                core_set_input_ready_q, core_set_input_ready_d;
  logic [N_CORES-1:0]  core_start_q, core_start_d;

  logic [N_CORES-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  sha256_core_dispatch_rr_arbiter #(
    .N     (N_CORES),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req         (core_ready),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d                = state_q;
    sel_d                  = sel_q;
    sel_oh_d               = sel_oh_q;
    rr_ptr_d               = rr_ptr_q;
    word_cnt_d             = word_cnt_q;
    blk_op_lat_d           = blk_op_lat_q;
    seq_bit_d              = seq_bit_q;
    core_wr_en_d           = '0;
    core_din_d             = core_din_q;
    core_wr_addr_d         = core_wr_addr_q;
    core_blk_op_d          = core_blk_op_q;
    core_seq_d             = core_seq_q;
    core_set_input_ready_d = 1'b0;
    core_start_d           = '0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid && arb_valid) begin
          sel_d    = arb_idx;
          sel_oh_d = arb_grant;
          rr_ptr_d = arb_idx;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The grant is committed here: core_ready is no longer consulted until IDLE.
        if (job_valid && job_ready_q) begin
          core_wr_en_d   = sel_oh_q;
          core_din_d     = job_data;
          core_wr_addr_d = word_cnt_q;
          core_seq_d     = seq_bit_q[sel_q];
          if (word_cnt_q == 4'd0) blk_op_lat_d = job_blk_op;
          word_cnt_d = word_cnt_q + 4'd1;
          if (word_cnt_q == LAST_WORD) state_d = ST_START;
        end
      end
      ST_START: begin
        core_start_d           = sel_oh_q;
        core_set_input_ready_d = 1'b1;
        core_seq_d             = seq_bit_q[sel_q];
        core_blk_op_d          = blk_op_lat_q;
        seq_bit_d[sel_q]       = ~seq_bit_q[sel_q];
        state_d                = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    job_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q                <= ST_IDLE;
      sel_q                  <= '0;
      sel_oh_q               <= '0;
      rr_ptr_q               <= IDX_W'(N_CORES - 1);
      word_cnt_q             <= '0;
      blk_op_lat_q           <= '0;
      seq_bit_q              <= '0;
      job_ready_q            <= 1'b0;
      busy_q                 <= 1'b0;
      core_wr_en_q           <= '0;
      core_din_q             <= '0;
      core_wr_addr_q         <= '0;
      core_blk_op_q          <= '0;
      core_seq_q             <= 1'b0;
      core_set_input_ready_q <= 1'b0;
      core_start_q           <= '0;
    end else begin
      state_q                <= state_d;
      sel_q                  <= sel_d;
      sel_oh_q               <= sel_oh_d;
      rr_ptr_q               <= rr_ptr_d;
      word_cnt_q             <= word_cnt_d;
      blk_op_lat_q           <= blk_op_lat_d;
      seq_bit_q              <= seq_bit_d;
      job_ready_q            <= job_ready_d;
      busy_q                 <= busy_d;
      core_wr_en_q           <= core_wr_en_d;
      core_din_q             <= core_din_d;
      core_wr_addr_q         <= core_wr_addr_d;
      core_blk_op_q          <= core_blk_op_d;
      core_seq_q             <= core_seq_d;
      core_set_input_ready_q <= core_set_input_ready_d;
      core_start_q           <= core_start_d;
    end
  end

  assign job_ready            = job_ready_q;
  assign busy                 = busy_q;
  assign core_wr_en           = core_wr_en_q;
  assign core_din             = core_din_q;
  assign core_wr_addr         = core_wr_addr_q;
  assign core_blk_op          = core_blk_op_q;
  assign core_seq             = core_seq_q;
  assign core_set_input_ready = core_set_input_ready_q;
  assign core_start           = core_start_q;

  // At most one core strobed (write or start) in any cycle.
  assert property (@(posedge CLK) disable iff (reset) $onehot0({core_wr_en_q, core_start_q}));

endmodule

// File: tb/tb_sha256_core_dispatch.sv
// tb/tb_sha256_core_dispatch.sv - randomized job-level bench with a transaction reference model
module tb_sha256_core_dispatch;
  import sha256_core_dispatch_pkg::*;

  localparam int NC = 3;

  logic                CLK = 1'b0;
  logic                reset;
  logic                job_valid;
  logic                job_ready;
  logic [31:0]         job_data;
  logic [BLK_OP_MSB:0] job_blk_op;
  logic [NC-1:0]       core_ready;
  logic [NC-1:0]       core_wr_en;
  logic [31:0]         core_din;
  logic [3:0]          core_wr_addr;
  logic [BLK_OP_MSB:0] core_blk_op;
  logic                core_seq;
  logic                core_set_input_ready;
  logic [NC-1:0]       core_start;
  logic                busy;

  sha256_core_dispatch #(.N_CORES(NC)) dut (
    .CLK                  (CLK),
    .reset                (reset),
    .job_valid            (job_valid),
    .job_ready            (job_ready),
    .job_data             (job_data),
    .job_blk_op           (job_blk_op),
    .core_ready           (core_ready),
    .core_wr_en           (core_wr_en),
    .core_din             (core_din),
    .core_wr_addr         (core_wr_addr),
    .core_blk_op          (core_blk_op),
    .core_seq             (core_seq),
    .core_set_input_ready (core_set_input_ready),
    .core_start           (core_start),
    .busy                 (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Job table
  logic [31:0]         j_data [64][16];
  logic [BLK_OP_MSB:0] j_op   [64];
  logic [NC-1:0]       j_rdy  [64];
  logic [NC-1:0]       j_mid  [64];
  int                  j_gap  [64];
  int                  j_hold [64];
  bit                  j_b2b  [64];
  int                  n_jobs = 0;

  // Reference model state: last granted core and per-core buffer bit
  int m_rr;
  int m_seq [NC];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick_core(input logic [NC-1:0] rdy, input int ptr);
    for (int i = 1; i <= NC; i++) begin
      int k;
      k = (ptr + i) % NC;
      if (((rdy >> k) & 3'd1) != 3'd0) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = NC - 1;
    for (int i = 0; i < NC; i++) m_seq[i] = 0;
  endtask

  task automatic add_job(input bit ramp, input logic [BLK_OP_MSB:0] op, input logic [NC-1:0] rdy,
                         input logic [NC-1:0] mid, input int gap, input int hold, input bit b2b);
    for (int i = 0; i < 16; i++) j_data[n_jobs][i] = ramp ? 32'(i) : $urandom;
    j_op[n_jobs]   = op;
    j_rdy[n_jobs]  = rdy;
    j_mid[n_jobs]  = mid;
    j_gap[n_jobs]  = gap;
    j_hold[n_jobs] = hold;
    j_b2b[n_jobs]  = b2b;
    n_jobs++;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    job_valid  = 1'b0;
    core_ready = '0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    model_reset();
    @(negedge CLK);
    expect_eq("rst_wr_en", 32'(core_wr_en), 32'd0);
    expect_eq("rst_start", 32'(core_start), 32'd0);
    expect_eq("rst_din", core_din, 32'd0);
    expect_eq("rst_addr", 32'(core_wr_addr), 32'd0);
    expect_eq("rst_blk_op", 32'(core_blk_op), 32'd0);
    expect_eq("rst_seq", 32'(core_seq), 32'd0);
    expect_eq("rst_sir", 32'(core_set_input_ready), 32'd0);
    expect_eq("rst_busy", 32'(busy), 32'd0);
    expect_eq("rst_job_ready", 32'(job_ready), 32'd0);
  endtask

  task automatic drive_jobs(input int first, input int cnt);
    for (int j = first; j < first + cnt; j++) begin
      int   w;
      int   t;
      logic jr_prev;
      w = 0;
      t = 0;
      if (j_hold[j] > 0) begin
        core_ready = '0;
        job_valid  = 1'b1;
        job_data   = j_data[j][0];
        job_blk_op = j_op[j];
        for (int h = 0; h < j_hold[j]; h++) begin
          @(negedge CLK);
          expect_eq("hold_job_ready", 32'(job_ready), 32'd0);
          expect_eq("hold_busy", 32'(busy), 32'd0);
          expect_eq("hold_strobes", 32'({core_wr_en, core_start}), 32'd0);
        end
      end
      core_ready = j_rdy[j];
      while (w < 16 && t < 400) begin
        case (j_gap[j])
          0:       job_valid = 1'b1;
          1:       job_valid = (t % 3 == 0);
          default: job_valid = 1'($urandom_range(0, 1));
        endcase
        job_data   = j_data[j][w];
        job_blk_op = (w == 0) ? j_op[j] : BLK_OP_MSB'(0) + (BLK_OP_MSB+1)'($urandom);
        jr_prev    = job_ready;
        @(negedge CLK);
        t++;
        if (job_valid && jr_prev) begin
          w++;
          if (w == 4) core_ready = j_mid[j];
        end
      end
      if (w < 16) expect_eq("drv_timeout", 32'(w), 32'd16);
      job_valid = 1'b0;
    end
  endtask

  task automatic monitor_jobs(input int first, input int cnt);
    int last_start;
    last_start = 0;
    for (int j = first; j < first + cnt; j++) begin
      int exp_core;
      int exp_seq;
      int nw;
      int first_cyc;
      int t;
      bit done;
      exp_core  = pick_core(j_rdy[j], m_rr);
      m_rr      = exp_core;
      exp_seq   = m_seq[exp_core];
      nw        = 0;
      first_cyc = 0;
      t         = 0;
      done      = 1'b0;
      while (!done && t < 600) begin
        @(negedge CLK);
        t++;
        expect_eq("sir_vs_start", 32'(core_set_input_ready), 32'(|core_start));
        if (|core_wr_en) begin
          expect_eq("wr_core", 32'(core_wr_en), 32'd1 << exp_core);
          expect_eq("wr_addr", 32'(core_wr_addr), 32'(nw));
          expect_eq("wr_data", core_din, j_data[j][nw % 16]);
          expect_eq("wr_seq", 32'(core_seq), 32'(exp_seq));
          expect_eq("wr_busy", 32'(busy), 32'd1);
          if (nw == 0) first_cyc = cyc;
          nw++;
        end
        if (|core_start) begin
          expect_eq("n_writes", 32'(nw), 32'd16);
          expect_eq("start_core", 32'(core_start), 32'd1 << exp_core);
          expect_eq("start_seq", 32'(core_seq), 32'(exp_seq));
          expect_eq("start_op", 32'(core_blk_op), 32'(j_op[j]));
          if (j_gap[j] == 0) expect_eq("latency", 32'(cyc - first_cyc), 32'd16);
          if (j_b2b[j]) expect_eq("period", 32'(cyc - last_start), 32'd18);
          last_start     = cyc;
          m_seq[exp_core] = 1 - m_seq[exp_core];
          done           = 1'b1;
        end
      end
      if (!done) expect_eq("start_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic run_phase(input int first, input int cnt);
    fork
      drive_jobs(first, cnt);
      monitor_jobs(first, cnt);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int w;
    int t;
    logic jr;

    reset      = 1'b1;
    job_valid  = 1'b0;
    job_data   = '0;
    job_blk_op = '0;
    core_ready = '0;
    model_reset();

    // Single ramp job, all cores ready
    do_reset();
    first = n_jobs;
    add_job(1'b1, 2'd1, 3'b111, 3'b111, 0, 0, 1'b0);
    run_phase(first, 1);

    // Four back-to-back jobs at full rate
    do_reset();
    first = n_jobs;
    for (int i = 0; i < 4; i++) add_job(1'b0, 2'($urandom), 3'b111, 3'b111, 0, 0, i > 0);
    run_phase(first, 4);

    // Only core 2 ready; its ready drops mid-load
    first = n_jobs;
    add_job(1'b0, 2'd2, 3'b100, 3'b000, 0, 0, 1'b0);
    run_phase(first, 1);

    // One valid word every third cycle
    first = n_jobs;
    add_job(1'b0, 2'($urandom), 3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), 1, 0, 1'b0);
    run_phase(first, 1);

    // No core ready for 20 cycles, then only core 1
    first = n_jobs;
    add_job(1'b0, 2'd3, 3'b010, 3'b010, 0, 20, 1'b0);
    run_phase(first, 1);

    // Randomized jobs: ready masks, mid-job ready changes, gaps
    first = n_jobs;
    for (int i = 0; i < 12; i++)
      add_job(1'b0, 2'($urandom), 3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 2)), 0, 1'b0);
    run_phase(first, 12);

    // Reset during load abandons the job
    do_reset();
    core_ready = 3'b111;
    w = 0;
    t = 0;
    while (w < 7 && t < 100) begin
      job_valid  = 1'b1;
      job_data   = 32'(w);
      job_blk_op = 2'd3;
      jr         = job_ready;
      @(negedge CLK);
      t++;
      if (jr) w++;
    end
    expect_eq("abort_words", 32'(w), 32'd7);
    reset     = 1'b1;
    job_valid = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    model_reset();
    expect_eq("abort_strobes", 32'({core_wr_en, core_start}), 32'd0);
    expect_eq("abort_sir", 32'(core_set_input_ready), 32'd0);
    expect_eq("abort_busy", 32'(busy), 32'd0);
    expect_eq("abort_job_ready", 32'(job_ready), 32'd0);
    expect_eq("abort_seq", 32'(core_seq), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      expect_eq("abort_no_start", 32'(core_start), 32'd0);
    end
    first = n_jobs;
    add_job(1'b0, 2'd1, 3'b111, 3'b111, 0, 0, 1'b0);
    run_phase(first, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
